// File: rtl/piso_mem_pkg.sv
// piso_mem_pkg: shared types and helpers for the piso_mem word buffer.
//   state_t    - controller state (IDLE waits for a frame, SEND streams it)
//   addr_width - width of the word-index counter for a given frame size
package piso_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Never returns 0 so that the index port stays a legal vector.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_mem_if.sv
// piso_mem_if: load and stream handshake bundle of piso_mem.
//   load_valid/load_ready/in              - parallel frame capture
//   out_valid/out_ready/out/out_addr/out_last - word-serial output
// Modports: slave (the buffer itself), master (producer + consumer side).
interface piso_mem_if #(
  parameter int unsigned IWIDTH  = 10,
  parameter int unsigned NINPUTS = 8
) ();

  localparam int unsigned AW = piso_mem_pkg::addr_width(NINPUTS);

  logic              load_valid;
  logic              load_ready;
  logic [IWIDTH-1:0] in [NINPUTS];
  logic              out_valid;
  logic              out_ready;
  logic [IWIDTH-1:0] out;
  logic [AW-1:0]     out_addr;
  logic              out_last;

  modport slave (
    input  load_valid, in, out_ready,
    output load_ready, out_valid, out, out_addr, out_last
  );

  modport master (
    output load_valid, in, out_ready,
    input  load_ready, out_valid, out, out_addr, out_last
  );

endinterface

// File: rtl/piso_mem_ctrl.sv
// piso_mem_ctrl: FSM, word-index counter and handshake decode for piso_mem.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   load_valid  - producer offers a frame
//   out_ready   - consumer accepts the current word
//   state       - registered FSM state
//   addr        - index of the word currently presented
//   capture     - load handshake this cycle (buffer write enable)
//   load_ready  - block can take a frame this cycle
// Macro PISO_MEM_B2B_EN: accept the next frame on the last beat (no bubble).
module piso_mem_ctrl
  import piso_mem_pkg::*;
#(
  parameter int unsigned NINPUTS = 8,
  parameter int unsigned AW      = addr_width(NINPUTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic          out_ready,
  output state_t        state,
  output logic [AW-1:0] addr,
  output logic          capture,
  output logic          load_ready
);

  localparam logic [AW-1:0] LAST = AW'(NINPUTS - 1);

  logic at_last;
  assign at_last = (state == SEND) && (addr == LAST);

`ifdef PISO_MEM_B2B_EN
  // Combinational out_ready -> load_ready path: the slot frees up on the
  // very edge that retires the last word.
  assign load_ready = (state == IDLE) || (at_last && out_ready);
`else
  assign load_ready = (state == IDLE);
`endif

  assign capture = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state <= SEND;
            addr  <= '0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (at_last) begin
              // Explicit wrap; capture can only be set here with B2B enabled.
              addr  <= '0;
              state <= capture ? SEND : IDLE;
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/piso_mem.sv
// piso_mem: parallel-in, serial-out word buffer. Captures NINPUTS words of
// IWIDTH bits in one load handshake, then streams them, index 0 first, one
// word per accepted beat with the word index and a last flag attached.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - piso_mem_if.slave (load_valid/load_ready/in,
//          out_valid/out_ready/out/out_addr/out_last)
// Optional macro PISO_MEM_B2B_EN: back-to-back frames with zero bubbles
// (adds a combinational out_ready -> load_ready path).
module piso_mem
  import piso_mem_pkg::*;
#(
  parameter int unsigned IWIDTH  = 10,
  parameter int unsigned NINPUTS = 8
) (
  input logic       clk,
  input logic       rst,
  piso_mem_if.slave bus
);

  localparam int unsigned   AW   = addr_width(NINPUTS);
  localparam logic [AW-1:0] LAST = AW'(NINPUTS - 1);

  state_t            state;
  logic [AW-1:0]     addr;
  logic              capture;
  logic [IWIDTH-1:0] buffer [NINPUTS];

  piso_mem_ctrl #(
    .NINPUTS (NINPUTS),
    .AW      (AW)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .load_valid (bus.load_valid),
    .out_ready  (bus.out_ready),
    .state      (state),
    .addr       (addr),
    .capture    (capture),
    .load_ready (bus.load_ready)
  );

  // Buffer only changes on a capture, so the presented word holds under
  // backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer <= '{default: '0};
    end else if (capture) begin
      for (int unsigned i = 0; i < NINPUTS; i++) begin
        buffer[i] <= bus.in[i];
      end
    end
  end

  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = (state == SEND) && (addr == LAST);
  assign bus.out_addr  = addr;
  assign bus.out       = buffer[addr];

endmodule

// File: tb/tb_piso_mem.sv
// tb_piso_mem: directed self-checking bench for piso_mem (8x10 default
// instance plus a 5x4 instance). Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_piso_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  piso_mem_if #(.IWIDTH(10), .NINPUTS(8)) bus  ();
  piso_mem_if #(.IWIDTH(4),  .NINPUTS(5)) bus5 ();

  piso_mem #(.IWIDTH(10), .NINPUTS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  piso_mem #(.IWIDTH(4), .NINPUTS(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic put_frame(input int base, input int step);
    for (int i = 0; i < 8; i++) bus.in[i] = 10'(base + step * i);
  endtask

  // Entered on the falling edge where word 0 is presented; out_ready held 1.
  task automatic drain(input string tag, input int base, input int step);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_valid[%0d]", tag, k), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_out[%0d]", tag, k),   32'(bus.out),       32'(base + step * k));
      check($sformatf("%s_addr[%0d]", tag, k),  32'(bus.out_addr),  32'(k));
      check($sformatf("%s_last[%0d]", tag, k),  32'(bus.out_last),  32'(k == 7));
      @(negedge clk);
    end
    check({tag, "_end_valid"}, 32'(bus.out_valid),  32'd0);
    check({tag, "_end_ready"}, 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    logic [10:0] pat;
    int          idx;

    bus.load_valid  = 1'b0;
    bus.out_ready   = 1'b0;
    bus5.load_valid = 1'b0;
    bus5.out_ready  = 1'b0;
    for (int i = 0; i < 8; i++) bus.in[i] = '0;
    for (int i = 0; i < 5; i++) bus5.in[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.out_valid),  32'd0);
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    check("rst_addr",  32'(bus.out_addr),   32'd0);
    check("rst_last",  32'(bus.out_last),   32'd0);
    check("rst_out",   32'(bus.out),        32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_valid", 32'(bus.out_valid), 32'd0);

    // Frame 3i+1 streamed with out_ready held high
    put_frame(1, 3);
    bus.load_valid = 1'b1;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    drain("t1", 1, 3);

    // Backpressure pattern 1,0,0,1,0,1,1,1,1,1,1 (bit c = cycle c)
    pat = 11'b11111101001;
    put_frame(1, 3);
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 11; c++) begin
      check($sformatf("t2_valid[%0d]", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("t2_out[%0d]", c),   32'(bus.out),       32'(3 * idx + 1));
      check($sformatf("t2_addr[%0d]", c),  32'(bus.out_addr),  32'(idx));
      check($sformatf("t2_last[%0d]", c),  32'(bus.out_last),  32'(idx == 7));
      bus.out_ready = pat[c];
      if (pat[c]) idx++;
      @(negedge clk);
    end
    check("t2_end_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

`ifdef PISO_MEM_B2B_EN
    // Two frames back to back: 16 beats, no bubble, addr wraps 7 -> 0
    put_frame(1, 3);
    bus.load_valid = 1'b1;
    @(negedge clk);
    put_frame(100, 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("b2b_valid[%0d]", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("b2b_out[%0d]", k),   32'(bus.out),
            (k < 8) ? 32'(3 * k + 1) : 32'(100 + k - 8));
      check($sformatf("b2b_addr[%0d]", k),  32'(bus.out_addr),  32'(k % 8));
      check($sformatf("b2b_last[%0d]", k),  32'(bus.out_last),  32'(k % 8 == 7));
      if (k < 8) check($sformatf("b2b_lready[%0d]", k), 32'(bus.load_ready), 32'(k == 7));
      if (k == 8) bus.load_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_end_valid", 32'(bus.out_valid), 32'd0);
`else
    // load_valid held during streaming is ignored; one bubble between frames
    put_frame(1, 3);
    bus.load_valid = 1'b1;
    @(negedge clk);
    put_frame(100, 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_lready[%0d]", k), 32'(bus.load_ready), 32'd0);
      check($sformatf("t3_out[%0d]", k),    32'(bus.out),        32'(3 * k + 1));
      check($sformatf("t3_addr[%0d]", k),   32'(bus.out_addr),   32'(k));
      @(negedge clk);
    end
    check("t3_bubble_valid", 32'(bus.out_valid),  32'd0);
    check("t3_bubble_ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    drain("t3b", 100, 1);
`endif

    // Asynchronous reset during beat 3
    put_frame(50, 1);
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_pre_addr", 32'(bus.out_addr), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("t4_async_valid", 32'(bus.out_valid),  32'd0);
    check("t4_async_addr",  32'(bus.out_addr),   32'd0);
    check("t4_async_last",  32'(bus.out_last),   32'd0);
    check("t4_async_ready", 32'(bus.load_ready), 32'd1);
    check("t4_async_out",   32'(bus.out),        32'd0);
    @(negedge clk);
    check("t4_held_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t4_wait_valid", 32'(bus.out_valid), 32'd0);
    put_frame(200, 2);
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    drain("t4", 200, 2);

    // 5-word, 4-bit instance: load 9,8,7,6,5
    for (int i = 0; i < 5; i++) bus5.in[i] = 4'(9 - i);
    bus5.load_valid = 1'b1;
    bus5.out_ready  = 1'b1;
    @(negedge clk);
    bus5.load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("n5_valid[%0d]", k), 32'(bus5.out_valid), 32'd1);
      check($sformatf("n5_out[%0d]", k),   32'(bus5.out),       32'(9 - k));
      check($sformatf("n5_addr[%0d]", k),  32'(bus5.out_addr),  32'(k));
      check($sformatf("n5_last[%0d]", k),  32'(bus5.out_last),  32'(k == 4));
      @(negedge clk);
    end
    check("n5_end_valid", 32'(bus5.out_valid),  32'd0);
    check("n5_end_addr",  32'(bus5.out_addr),   32'd0);
    check("n5_end_ready", 32'(bus5.load_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
